if_fetch: RTL
=============

# if_fetch

Dual-issue instruction fetch stage feeding the IF/ID instruction buffer. Fetches one aligned 64-bit pair per memory transaction, predecodes branches, applies static prediction, and presents one or two instructions with pc/npc/prediction bits and an `issue` code. Honours buffer back-pressure (`instbuf_full`) and redirects from execute on mispredict.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `instbuf_full`  in  1  buffer cannot accept this cycle.
- `redirect_valid`  in  1  execute redirect (mispredict or jalr); one-cycle pulse.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored.
- `imem_req`  out  1  memory request.
- `imem_addr`  out  32  request address, `pc & ~7`.
- `imem_ack`  in  1  response valid this cycle; may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  64  [31:0] = word at addr, [63:32] = word at addr+4.
- `issue`  out  2  00 none, 01 one instruction on slot 2 ports, 11 two instructions.
- `out1_inst`/`out1_pc`/`out1_npc`  out  32 each  slot 1.
- `out2_inst`/`out2_pc`/`out2_npc`  out  32 each  slot 2.
- `isbranch1`, `br_taken1`, `isbranch2`, `br_taken2`  out  1 each  predecode/prediction per slot.
- `stop`  out  1  high while a discarded response is pending (state DROP).

## Operation
- States: IDLE, REQ, ISSUE, DROP. Reset: state IDLE, `pc`=RESET_PC, all outputs 0.
- IDLE -> REQ unconditionally on the next edge.
- REQ: `imem_req`=1, `imem_addr` = `pc & ~7`, held stable until ack. On ack: decode and register outputs, -> ISSUE.
- Predecode per word: B-type (opcode 1100011) and JAL (1101111) set isbranch; JALR is not a branch (isbranch=0).
- Targets: B = pc + sext({i[31],i[7],i[30:25],i[11:8],0}); J = pc + sext({i[31],i[19:12],i[20],i[30:21],0}). All pc arithmetic is 32-bit modulo.
- JAL is always predicted taken. B-type prediction is set by configuration. Taken: npc = target; otherwise npc = pc+4.
- Slot selection:
  - `pc[2]`=1: only upper word, placed on slot 2, `issue`=01.
  - `pc[2]`=0 and lower word predicted taken: lower word placed on slot 2, `issue`=01.
  - Otherwise: lower on slot 1, upper on slot 2, `issue`=11.
- Unused slot fields are 0.
- ISSUE: outputs held stable. Accepted at an edge with `instbuf_full`=0; then `pc` <= npc of the last delivered instruction, `issue` <= 00, -> REQ.
- Redirect (`redirect_valid`) has priority at every edge; it sets `pc` <= `{redirect_pc[31:2],2'b00}` and `issue` <= 00:
  - IDLE/ISSUE: -> REQ.
  - REQ with ack in the same cycle: response dropped, -> REQ.
  - REQ without ack: -> DROP.
  - DROP: stays DROP with the updated pc.
- DROP: `imem_req` stays 1 with the old address until ack; the response is discarded, then -> REQ with the new pc.
- Async reset mid-transaction abandons any outstanding request; memory must tolerate a dropped req.

## Timing
- Single outstanding request. Outputs are registered, so `issue` is nonzero the cycle after ack.
- Best case 2 cycles per pair: ack in the REQ cycle, accept in the ISSUE cycle.
- `imem_req` is a combinational decode of state. `issue` and payload stay constant while `instbuf_full`=1.
- `stop` = (state==DROP).

## Configuration
- `IF_STATIC_PRED_EN` defined: B-type predicted taken iff its immediate is negative (backward-taken, forward-not-taken). `br_taken` and npc reflect the prediction.
- Undefined: B-type always predicted not-taken (`br_taken`=0, npc=pc+4). JAL is still predicted taken.

## Test plan
- Reset, memory always-ack with rdata {0x00000013,0x00000013}: `issue`=11, out1_pc=0, out2_pc=4, npcs 4/8; next request addr 8.
- Redirect to 0x104: fetch addr 0x100, `issue`=01, out2_pc=0x104, out2_npc=0x108, out1 fields 0.
- pc=0x200, lower word 0x0100006F (jal +16): `issue`=01, out2_pc=0x200, npc=0x210, isbranch2=br_taken2=1; next addr 0x210.
- pc=0x40, lower word 0xFE000CE3 (beq -8): with macro, `issue`=01, npc=0x38, next addr 0x38; without macro, `issue`=11, npc1=0x44, br_taken1=0.
- Hold `instbuf_full`=1 for 5 cycles in ISSUE: outputs stable, no new `imem_req`; release, accepted at the next edge.
- Delay ack 3 cycles, pulse redirect to 0x300 in cycle 1: `stop`=1 until ack, old data not issued, then request addr 0x300.

Source files
------------

// File: rtl/if_fetch.sv
// Dual-issue fetch: one aligned 64-bit pair per request, registered issue 1 cycle after ack, held while instbuf_full.
// Define IF_STATIC_PRED_EN for backward-taken/forward-not-taken B-type prediction; otherwise B-type is predicted not-taken.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instbuf_full,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [63:0] imem_rdata,
    output logic [1:0]  issue,
    output logic [31:0] out1_inst,
    output logic [31:0] out1_pc,
    output logic [31:0] out1_npc,
    output logic [31:0] out2_inst,
    output logic [31:0] out2_pc,
    output logic [31:0] out2_npc,
    output logic        isbranch1,
    output logic        br_taken1,
    output logic        isbranch2,
    output logic        br_taken2,
    output logic        stop
);
    typedef enum logic [1:0] {IDLE, REQ, ISSUE, DROP} state_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drop_addr;

    function automatic logic is_br(input logic [31:0] i);
        return (i[6:0] == OP_BRANCH) || (i[6:0] == OP_JAL);
    endfunction

    function automatic logic [31:0] br_target(input logic [31:0] i, input logic [31:0] p);
        if (i[6:0] == OP_JAL)
            return p + {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        return p + {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic pred_taken(input logic [31:0] i);
        if (i[6:0] == OP_JAL)
            return 1'b1;
`ifdef IF_STATIC_PRED_EN
        if (i[6:0] == OP_BRANCH)
            return i[31];
`endif
        return 1'b0;
    endfunction

    logic [31:0] pc_lo, pc_hi, inst_lo, inst_hi, npc_lo, npc_hi;
    logic        br_lo, br_hi, tk_lo, tk_hi;

    assign pc_lo   = {pc[31:3], 3'b000};
    assign pc_hi   = pc_lo + 32'd4;
    assign inst_lo = imem_rdata[31:0];
    assign inst_hi = imem_rdata[63:32];
    assign br_lo   = is_br(inst_lo);
    assign br_hi   = is_br(inst_hi);
    assign tk_lo   = pred_taken(inst_lo);
    assign tk_hi   = pred_taken(inst_hi);
    assign npc_lo  = tk_lo ? br_target(inst_lo, pc_lo) : pc_lo + 32'd4;
    assign npc_hi  = tk_hi ? br_target(inst_hi, pc_hi) : pc_hi + 32'd4;

    // The response address must stay put in DROP even though pc already holds the redirect target.
    assign imem_req  = (state == REQ) || (state == DROP);
    assign imem_addr = (state == DROP) ? drop_addr :
                       (state == REQ)  ? pc_lo     : 32'd0;
    assign stop      = (state == DROP);

    logic unused_bits;
    assign unused_bits = ^{redirect_pc[1:0], pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop_addr <= 32'd0;
            issue     <= 2'b00;
            out1_inst <= 32'd0;
            out1_pc   <= 32'd0;
            out1_npc  <= 32'd0;
            out2_inst <= 32'd0;
            out2_pc   <= 32'd0;
            out2_npc  <= 32'd0;
            isbranch1 <= 1'b0;
            br_taken1 <= 1'b0;
            isbranch2 <= 1'b0;
            br_taken2 <= 1'b0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            issue <= 2'b00;
            case (state)
                DROP: state <= DROP;
                REQ: begin
                    if (imem_ack) begin
                        state <= REQ;
                    end else begin
                        state     <= DROP;
                        drop_addr <= pc_lo;
                    end
                end
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_ack) begin
                        state <= ISSUE;
                        if (pc[2] || tk_lo) begin
                            issue     <= 2'b01;
                            out1_inst <= 32'd0;
                            out1_pc   <= 32'd0;
                            out1_npc  <= 32'd0;
                            isbranch1 <= 1'b0;
                            br_taken1 <= 1'b0;
                            out2_inst <= pc[2] ? inst_hi : inst_lo;
                            out2_pc   <= pc[2] ? pc_hi   : pc_lo;
                            out2_npc  <= pc[2] ? npc_hi  : npc_lo;
                            isbranch2 <= pc[2] ? br_hi   : br_lo;
                            br_taken2 <= pc[2] ? tk_hi   : tk_lo;
                        end else begin
                            issue     <= 2'b11;
                            out1_inst <= inst_lo;
                            out1_pc   <= pc_lo;
                            out1_npc  <= npc_lo;
                            isbranch1 <= br_lo;
                            br_taken1 <= tk_lo;
                            out2_inst <= inst_hi;
                            out2_pc   <= pc_hi;
                            out2_npc  <= npc_hi;
                            isbranch2 <= br_hi;
                            br_taken2 <= tk_hi;
                        end
                    end
                end
                ISSUE: begin
                    // Slot 2 always carries the last delivered instruction.
                    if (!instbuf_full) begin
                        pc    <= out2_npc;
                        issue <= 2'b00;
                        state <= REQ;
                    end
                end
                DROP: begin
                    if (imem_ack)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
